// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file write-back scheduler.
// Also holds the requester-id encoding used by the arbiter and the top.
package regfile_wb_scheduler_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = 5;

   localparam logic [AW-1:0] REG_ZERO = '0;

   // Requester ids double as bit positions in the req/gnt vectors.
   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue, write-back requester and register-file write-port signals of the scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface regfile_wb_scheduler_if;
   import regfile_wb_scheduler_pkg::*;

   logic            issue_valid;
   logic [AW-1:0]   issue_rd;
   logic            issue_rd_used;
   logic [AW-1:0]   issue_rs1;
   logic [AW-1:0]   issue_rs2;
   logic            issue_stall;

   logic            alu_req;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ack;

   logic            mem_req;
   logic [AW-1:0]   mem_rd;
   logic [XLEN-1:0] mem_data;
   logic            mem_ack;

   logic            write_enable;
   logic [AW-1:0]   reg_enc_write;
   logic [XLEN-1:0] reg_w;
   logic [NREG-1:0] pending;

   modport slave (
      input  issue_valid, issue_rd, issue_rd_used, issue_rs1, issue_rs2,
      input  alu_req, alu_rd, alu_data, mem_req, mem_rd, mem_data,
      output issue_stall, alu_ack, mem_ack,
      output write_enable, reg_enc_write, reg_w, pending
   );

   modport master (
      output issue_valid, issue_rd, issue_rd_used, issue_rs1, issue_rs2,
      output alu_req, alu_rd, alu_data, mem_req, mem_rd, mem_data,
      input  issue_stall, alu_ack, mem_ack,
      input  write_enable, reg_enc_write, reg_w, pending
   );

endinterface

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Two-way round-robin arbiter for the shared register-file write port.
// rr_last remembers the most recent winner; on conflict the other requester wins.
module wb_rr_arbiter
   import regfile_wb_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic rr_last_q, rr_last_d;

   always_comb begin
      gnt       = 2'b00;
      rr_last_d = rr_last_q;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (rr_last_q == REQ_ALU) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
      if (gnt[REQ_MEM]) begin
         rr_last_d = REQ_MEM;
      end else if (gnt[REQ_ALU]) begin
         rr_last_d = REQ_ALU;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_last_q <= REQ_ALU;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and scoreboard: arbitrates ALU/load write-backs onto the
// single register-file write port and stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
(
   input logic                   clk,
   input logic                   rst,
   regfile_wb_scheduler_if.slave bus
);

   logic [1:0]      req, gnt;
   logic            any_gnt;
   logic [AW-1:0]   gnt_rd;
   logic [XLEN-1:0] gnt_data;
   logic            issue_accept;
   logic [NREG-1:0] pending_q, pending_d;
   logic            we_q;
   logic [AW-1:0]   wr_idx_q;
   logic [XLEN-1:0] wr_data_q;

   assign req = {bus.mem_req, bus.alu_req};

   wb_rr_arbiter u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   assign bus.alu_ack = gnt[REQ_ALU];
   assign bus.mem_ack = gnt[REQ_MEM];
   assign any_gnt     = |gnt;

   always_comb begin
      gnt_rd   = bus.alu_rd;
      gnt_data = bus.alu_data;
      if (gnt[REQ_MEM]) begin
         gnt_rd   = bus.mem_rd;
         gnt_data = bus.mem_data;
      end
   end

   // pending[0] is never set, so x0 can never cause a stall.
   assign bus.issue_stall = bus.issue_valid &
                            (pending_q[bus.issue_rs1] | pending_q[bus.issue_rs2] |
                             (bus.issue_rd_used & pending_q[bus.issue_rd]));
   assign issue_accept    = bus.issue_valid & ~bus.issue_stall;

   // Clear first, then set, so an issue set wins over a same-index clear.
   always_comb begin
      pending_d = pending_q;
      if (we_q) begin
         pending_d[wr_idx_q] = 1'b0;
      end
      if (issue_accept && bus.issue_rd_used && bus.issue_rd != REG_ZERO) begin
         pending_d[bus.issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= '0;
         we_q      <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
      end else begin
         pending_q <= pending_d;
         we_q      <= any_gnt && (gnt_rd != REG_ZERO);
         if (any_gnt) begin
            wr_idx_q  <= gnt_rd;
            wr_data_q <= gnt_data;
         end
      end
   end

   assign bus.write_enable  = we_q;
   assign bus.reg_enc_write = wr_idx_q;
   assign bus.reg_w         = wr_data_q;
   assign bus.pending       = pending_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: reset, RAW/WAW stalls, arbitration,
// x0 handling and asynchronous reset during an in-flight write.
module tb_regfile_wb_scheduler;
   import regfile_wb_scheduler_pkg::*;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   regfile_wb_scheduler_if bus ();

   regfile_wb_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      bus.issue_valid   = 1'b0;
      bus.issue_rd      = '0;
      bus.issue_rd_used = 1'b0;
      bus.issue_rs1     = '0;
      bus.issue_rs2     = '0;
      bus.alu_req       = 1'b0;
      bus.alu_rd        = '0;
      bus.alu_data      = '0;
      bus.mem_req       = 1'b0;
      bus.mem_rd        = '0;
      bus.mem_data      = '0;
   endtask

   task automatic test_reset();
      #3 rst = 1'b0;
      #1;
      vectors++;
      if (bus.pending !== 32'h0 || bus.write_enable !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_state: pending=%h we=%b, want 0/0", bus.pending, bus.write_enable);
      end
      vectors++;
      if (bus.reg_enc_write !== 5'd0 || bus.reg_w !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_port: idx=%0d data=%h, want 0/0", bus.reg_enc_write, bus.reg_w);
      end
      vectors++;
      if (bus.issue_stall !== 1'b0 || bus.alu_ack !== 1'b0 || bus.mem_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_comb: stall=%b aack=%b mack=%b, want 000",
                  bus.issue_stall, bus.alu_ack, bus.mem_ack);
      end
      @(negedge clk);
      rst = 1'b1;
      step();
      step();
      vectors++;
      if (bus.write_enable !== 1'b0 || bus.pending !== 32'h0) begin
         miscompares++;
         $display("FAIL idle: we=%b pending=%h, want 0/0", bus.write_enable, bus.pending);
      end
   endtask

   task automatic test_raw();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.issue_rd_used = 1'b1;
      settle();
      vectors++;
      if (bus.issue_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL raw_first_issue: stall=%b want 0", bus.issue_stall);
      end
      step();
      bus.issue_rd = 5'd6; bus.issue_rs1 = 5'd5;
      bus.alu_req = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
      settle();
      vectors++;
      if (bus.pending !== 32'h0000_0020 || bus.issue_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL raw_stall: pending=%h stall=%b, want 00000020/1",
                  bus.pending, bus.issue_stall);
      end
      vectors++;
      if (bus.alu_ack !== 1'b1 || bus.mem_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL raw_ack: aack=%b mack=%b, want 1/0", bus.alu_ack, bus.mem_ack);
      end
      step();
      bus.alu_req = 1'b0;
      settle();
      vectors++;
      if (bus.write_enable !== 1'b1 || bus.reg_enc_write !== 5'd5 || bus.reg_w !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL raw_write: we=%b idx=%0d data=%h, want 1/5/deadbeef",
                  bus.write_enable, bus.reg_enc_write, bus.reg_w);
      end
      vectors++;
      if (bus.issue_stall !== 1'b1 || bus.pending !== 32'h0000_0020) begin
         miscompares++;
         $display("FAIL raw_no_bypass: stall=%b pending=%h, want 1/00000020",
                  bus.issue_stall, bus.pending);
      end
      step();
      vectors++;
      if (bus.issue_stall !== 1'b0 || bus.pending !== 32'h0 || bus.write_enable !== 1'b0) begin
         miscompares++;
         $display("FAIL raw_release: stall=%b pending=%h we=%b, want 0/0/0",
                  bus.issue_stall, bus.pending, bus.write_enable);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_conflict();
      bus.alu_req = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hAAAA_0003;
      bus.mem_req = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'hBBBB_0004;
      settle();
      vectors++;
      if (bus.mem_ack !== 1'b1 || bus.alu_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL conf_c1: mack=%b aack=%b, want 1/0", bus.mem_ack, bus.alu_ack);
      end
      step();
      bus.mem_req = 1'b0;
      settle();
      vectors++;
      if (bus.alu_ack !== 1'b1 || bus.mem_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL conf_c2: aack=%b mack=%b, want 1/0", bus.alu_ack, bus.mem_ack);
      end
      vectors++;
      if (bus.write_enable !== 1'b1 || bus.reg_enc_write !== 5'd4 || bus.reg_w !== 32'hBBBB_0004) begin
         miscompares++;
         $display("FAIL conf_wr_x4: we=%b idx=%0d data=%h, want 1/4/bbbb0004",
                  bus.write_enable, bus.reg_enc_write, bus.reg_w);
      end
      step();
      bus.alu_req = 1'b0;
      vectors++;
      if (bus.write_enable !== 1'b1 || bus.reg_enc_write !== 5'd3 || bus.reg_w !== 32'hAAAA_0003) begin
         miscompares++;
         $display("FAIL conf_wr_x3: we=%b idx=%0d data=%h, want 1/3/aaaa0003",
                  bus.write_enable, bus.reg_enc_write, bus.reg_w);
      end
      step();
      vectors++;
      if (bus.write_enable !== 1'b0 || bus.reg_enc_write !== 5'd3 || bus.reg_w !== 32'hAAAA_0003) begin
         miscompares++;
         $display("FAIL conf_hold: we=%b idx=%0d data=%h, want 0/3/aaaa0003",
                  bus.write_enable, bus.reg_enc_write, bus.reg_w);
      end
   endtask

   // Continuous contention: ALU won last, so grants alternate MEM, ALU, MEM.
   task automatic test_back_to_back();
      bus.alu_req = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h0000_000A;
      bus.mem_req = 1'b1; bus.mem_rd = 5'd11; bus.mem_data = 32'h0000_000B;
      settle();
      vectors++;
      if (bus.mem_ack !== 1'b1 || bus.alu_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_g1: mack=%b aack=%b, want 1/0", bus.mem_ack, bus.alu_ack);
      end
      step();
      bus.mem_rd = 5'd12; bus.mem_data = 32'h0000_000C;
      settle();
      vectors++;
      if (bus.alu_ack !== 1'b1 || bus.mem_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_g2: aack=%b mack=%b, want 1/0", bus.alu_ack, bus.mem_ack);
      end
      step();
      bus.alu_rd = 5'd13; bus.alu_data = 32'h0000_000D;
      settle();
      vectors++;
      if (bus.mem_ack !== 1'b1 || bus.alu_ack !== 1'b0 || bus.reg_enc_write !== 5'd10) begin
         miscompares++;
         $display("FAIL b2b_g3: mack=%b aack=%b idx=%0d, want 1/0/10",
                  bus.mem_ack, bus.alu_ack, bus.reg_enc_write);
      end
      step();
      bus.mem_req = 1'b0;
      vectors++;
      if (bus.reg_enc_write !== 5'd12 || bus.reg_w !== 32'h0000_000C) begin
         miscompares++;
         $display("FAIL b2b_wr: idx=%0d data=%h, want 12/0000000c", bus.reg_enc_write, bus.reg_w);
      end
      step();
      bus.alu_req = 1'b0;
      step();
   endtask

   task automatic test_x0();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.issue_rd_used = 1'b1;
      bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0;
      settle();
      vectors++;
      if (bus.issue_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL x0_issue: stall=%b want 0", bus.issue_stall);
      end
      step();
      bus.issue_valid = 1'b0;
      bus.mem_req = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h0000_1234;
      settle();
      vectors++;
      if (bus.pending !== 32'h0 || bus.mem_ack !== 1'b1) begin
         miscompares++;
         $display("FAIL x0_ack: pending=%h mack=%b, want 0/1", bus.pending, bus.mem_ack);
      end
      step();
      bus.mem_req = 1'b0;
      vectors++;
      if (bus.write_enable !== 1'b0 || bus.reg_enc_write !== 5'd0 || bus.reg_w !== 32'h0000_1234) begin
         miscompares++;
         $display("FAIL x0_nowrite: we=%b idx=%0d data=%h, want 0/0/00001234",
                  bus.write_enable, bus.reg_enc_write, bus.reg_w);
      end
      step();
   endtask

   task automatic test_waw();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.issue_rd_used = 1'b1;
      bus.issue_rs1 = 5'd1; bus.issue_rs2 = 5'd1;
      step();
      vectors++;
      if (bus.pending !== 32'h0000_0080 || bus.issue_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL waw_stall: pending=%h stall=%b, want 00000080/1",
                  bus.pending, bus.issue_stall);
      end
      bus.issue_rd_used = 1'b0;
      settle();
      vectors++;
      if (bus.issue_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL waw_rd_unused: stall=%b want 0", bus.issue_stall);
      end
      bus.issue_valid = 1'b0;
      step();
      bus.issue_valid = 1'b1; bus.issue_rd_used = 1'b1;
      bus.alu_req = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7777_7777;
      step();
      bus.alu_req = 1'b0;
      vectors++;
      if (bus.issue_stall !== 1'b1 || bus.write_enable !== 1'b1 || bus.reg_enc_write !== 5'd7) begin
         miscompares++;
         $display("FAIL waw_hold: stall=%b we=%b idx=%0d, want 1/1/7",
                  bus.issue_stall, bus.write_enable, bus.reg_enc_write);
      end
      step();
      vectors++;
      if (bus.issue_stall !== 1'b0 || bus.pending !== 32'h0) begin
         miscompares++;
         $display("FAIL waw_release: stall=%b pending=%h, want 0/0", bus.issue_stall, bus.pending);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_reset_mid_write();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.issue_rd_used = 1'b1;
      step();
      bus.issue_valid = 1'b0;
      bus.alu_req = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h9999_0009;
      settle();
      vectors++;
      if (bus.alu_ack !== 1'b1 || bus.pending !== 32'h0000_0200) begin
         miscompares++;
         $display("FAIL rmw_grant: aack=%b pending=%h, want 1/00000200", bus.alu_ack, bus.pending);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (bus.pending !== 32'h0 || bus.write_enable !== 1'b0) begin
         miscompares++;
         $display("FAIL rmw_async: pending=%h we=%b, want 0/0", bus.pending, bus.write_enable);
      end
      step();
      bus.alu_req = 1'b0;
      vectors++;
      if (bus.write_enable !== 1'b0 || bus.reg_enc_write !== 5'd0 || bus.reg_w !== 32'h0) begin
         miscompares++;
         $display("FAIL rmw_dropped: we=%b idx=%0d data=%h, want 0/0/0",
                  bus.write_enable, bus.reg_enc_write, bus.reg_w);
      end
      #3 rst = 1'b1;
      step();
      vectors++;
      if (bus.write_enable !== 1'b0 || bus.pending !== 32'h0) begin
         miscompares++;
         $display("FAIL rmw_after: we=%b pending=%h, want 0/0", bus.write_enable, bus.pending);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      clear_inputs();
      test_reset();
      test_raw();
      test_conflict();
      test_back_to_back();
      test_x0();
      test_waw();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
